// File: rtl/pf_pkg.sv
// Types and constants shared by the ingress framing path and dest_calculator.
package pf_pkg;

  localparam int HDR_HWORDS = 3;
  localparam logic [1:0] LAST_HWORD = 2'(HDR_HWORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY,
    ST_PAD,
    ST_GAP,
    ST_DROP
  } parser_state_e;

  typedef union packed {
    logic [15:0] hw;
    struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
    } bytes;
  } mac_t;

endpackage

// File: rtl/ingress_parser.sv
// Ingress framing stage: forwards a 16-bit packet stream through one register
// stage and emits exactly three destination-MAC strobes per frame.
module ingress_parser
  import pf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  input  logic        out_ready,
  output logic        dst_mac_valid,
  output logic [15:0] mac_data,
  output logic        frame_err
);

  parser_state_e state, state_nxt;
  logic [1:0]    hdr_cnt, hdr_cnt_nxt;
  logic          abort_q, abort_nxt;
  logic          accept;
  logic          fwd, fwd_abort, strobe, strobe_pad, err_pulse;
  mac_t          mac_q;

  assign in_ready = (!out_valid || out_ready) &&
                    (state inside {ST_IDLE, ST_HDR, ST_BODY, ST_DROP});
  assign accept   = in_valid && in_ready;
  assign mac_data = mac_q.hw;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      hdr_cnt <= 2'd0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      hdr_cnt <= hdr_cnt_nxt;
      abort_q <= abort_nxt;
    end
  end

  // hdr_cnt holds the number of strobes already issued for the current frame.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt   = state;
    hdr_cnt_nxt = hdr_cnt;
    abort_nxt   = abort_q;
    unique case (state)
      ST_IDLE: if (accept) begin
        if (in_sop) begin
          hdr_cnt_nxt = 2'd1;
          abort_nxt   = 1'b0;
          state_nxt   = in_eop ? ST_PAD : ST_HDR;
        end else if (!in_eop) begin
          state_nxt = ST_DROP;
        end
      end
      ST_HDR: if (accept) begin
        if (in_sop) begin
          // The interrupting frame is discarded up to its own eop.
          abort_nxt = !in_eop;
          state_nxt = ST_PAD;
        end else begin
          hdr_cnt_nxt = hdr_cnt + 2'd1;
          if (hdr_cnt == LAST_HWORD) state_nxt = in_eop ? ST_GAP : ST_BODY;
          else if (in_eop)           state_nxt = ST_PAD;
        end
      end
      ST_BODY: if (accept) begin
        if (in_sop)      state_nxt = in_eop ? ST_IDLE : ST_DROP;
        else if (in_eop) state_nxt = ST_IDLE;
      end
      ST_PAD: begin
        hdr_cnt_nxt = hdr_cnt + 2'd1;
        if (hdr_cnt == LAST_HWORD) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        abort_nxt = 1'b0;
        state_nxt = abort_q ? ST_DROP : ST_IDLE;
      end
      ST_DROP: if (accept && in_eop) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fwd        = 1'b0;
    fwd_abort  = 1'b0;
    strobe     = 1'b0;
    strobe_pad = 1'b0;
    err_pulse  = 1'b0;
    unique case (state)
      ST_IDLE: if (accept) begin
        fwd       = in_sop;
        strobe    = in_sop;
        err_pulse = !in_sop || in_eop;
      end
      ST_HDR: if (accept) begin
        fwd       = 1'b1;
        fwd_abort = in_sop;
        strobe    = !in_sop;
        err_pulse = in_sop || (in_eop && hdr_cnt != LAST_HWORD);
      end
      ST_BODY: if (accept) begin
        fwd       = 1'b1;
        fwd_abort = in_sop;
        err_pulse = in_sop;
      end
      ST_PAD: begin
        strobe     = 1'b1;
        strobe_pad = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register stage; the strobe path ignores output backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_data      <= 16'd0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_err       <= 1'b0;
      dst_mac_valid <= 1'b0;
      mac_q         <= '0;
      frame_err     <= 1'b0;
    end else begin
      if (fwd) begin
        out_valid <= 1'b1;
        out_data  <= fwd_abort ? 16'd0 : in_data;
        out_sop   <= fwd_abort ? 1'b0  : in_sop;
        out_eop   <= fwd_abort ? 1'b1  : in_eop;
        out_err   <= fwd_abort;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      dst_mac_valid <= strobe;
      mac_q.hw      <= (strobe && !strobe_pad) ? in_data : 16'd0;
      frame_err     <= err_pulse;
    end
  end

endmodule

// File: tb/tb_ingress_parser.sv
// Directed self-checking bench for ingress_parser: strobes, framing errors,
// inter-frame gap, backpressure and reset recovery.
module tb_ingress_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_sop, out_eop, out_err, out_ready;
  logic        dst_mac_valid;
  logic [15:0] mac_data;
  logic        frame_err;

  ingress_parser dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_err(out_err), .out_ready(out_ready),
    .dst_mac_valid(dst_mac_valid), .mac_data(mac_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [15:0] strobe_q[$];
  int          strobe_cyc_q[$];
  logic [18:0] beat_q[$];        // {sop, eop, err, data}
  int          ferr_cnt;
  int          rdy_low_cnt;

  logic [17:0] stim_q[$];        // {sop, eop, data}
  int          acc_q[$];
  logic [15:0] exp_strobe_q[$];
  int          exp_scyc_q[$];
  logic [18:0] exp_beat_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (dst_mac_valid) begin
        strobe_q.push_back(mac_data);
        strobe_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) beat_q.push_back({out_sop, out_eop, out_err, out_data});
      if (frame_err) ferr_cnt++;
      if (!in_ready) rdy_low_cnt++;
    end
  end

  task automatic clear_logs();
    strobe_q.delete();
    strobe_cyc_q.delete();
    beat_q.delete();
    ferr_cnt    = 0;
    rdy_low_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_stim(input logic [15:0] d, input logic s, input logic e);
    stim_q.push_back({s, e, d});
  endtask

  task automatic exp_beat(input logic [15:0] d, input logic s, input logic e, input logic err);
    exp_beat_q.push_back({s, e, err, d});
  endtask

  task automatic send(input logic [15:0] d, input logic s, input logic e, output int acc_cyc);
    logic rdy;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    acc_cyc  = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) check("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic drive_queue();
    int a;
    acc_q.delete();
    foreach (stim_q[i]) begin
      send(stim_q[i][15:0], stim_q[i][17], stim_q[i][16], a);
      acc_q.push_back(a);
    end
    stim_q.delete();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic compare_logs(input string tag, input int exp_ferr);
    check({tag, "_strobe_cnt"}, 32'(strobe_q.size()), 32'(exp_strobe_q.size()));
    foreach (exp_strobe_q[i]) begin
      check($sformatf("%s_strobe%0d", tag, i),
            32'((i < strobe_q.size()) ? strobe_q[i] : 16'hxxxx), 32'(exp_strobe_q[i]));
    end
    foreach (exp_scyc_q[i]) begin
      check($sformatf("%s_strobe_cyc%0d", tag, i),
            32'((i < strobe_cyc_q.size()) ? strobe_cyc_q[i] : -1), 32'(exp_scyc_q[i]));
    end
    check({tag, "_beat_cnt"}, 32'(beat_q.size()), 32'(exp_beat_q.size()));
    foreach (exp_beat_q[i]) begin
      check($sformatf("%s_beat%0d", tag, i),
            32'((i < beat_q.size()) ? beat_q[i] : 19'hxxxxx), 32'(exp_beat_q[i]));
    end
    check({tag, "_frame_err"}, 32'(ferr_cnt), 32'(exp_ferr));
    exp_strobe_q.delete();
    exp_scyc_q.delete();
    exp_beat_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_data   = 16'd0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    out_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_flags", 32'({out_sop, out_eop, out_err}), 32'd0);
    check("rst_strobe", 32'(dst_mac_valid), 32'd0);
    check("rst_mac_data", 32'(mac_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    idle(1);

    // 8-beat frame, no backpressure
    clear_logs();
    push_stim(16'h0011, 1, 0); push_stim(16'h2233, 0, 0); push_stim(16'h4455, 0, 0);
    push_stim(16'h6677, 0, 0); push_stim(16'h8899, 0, 0); push_stim(16'hAABB, 0, 0);
    push_stim(16'hCCDD, 0, 0); push_stim(16'hEEFF, 0, 1);
    drive_queue();
    idle(5);
    exp_strobe_q = '{16'h0011, 16'h2233, 16'h4455};
    exp_scyc_q   = '{acc_q[0], acc_q[0] + 1, acc_q[0] + 2};
    exp_beat(16'h0011, 1, 0, 0); exp_beat(16'h2233, 0, 0, 0); exp_beat(16'h4455, 0, 0, 0);
    exp_beat(16'h6677, 0, 0, 0); exp_beat(16'h8899, 0, 0, 0); exp_beat(16'hAABB, 0, 0, 0);
    exp_beat(16'hCCDD, 0, 0, 0); exp_beat(16'hEEFF, 0, 1, 0);
    compare_logs("frame8", 0);
    check("frame8_rdy_low", 32'(rdy_low_cnt), 32'd0);

    // single-beat runt: one real strobe, two pad strobes, then a gap cycle
    clear_logs();
    push_stim(16'hABCD, 1, 1);
    drive_queue();
    idle(6);
    exp_strobe_q = '{16'hABCD, 16'h0000, 16'h0000};
    exp_scyc_q   = '{acc_q[0], acc_q[0] + 1, acc_q[0] + 2};
    exp_beat(16'hABCD, 1, 1, 0);
    compare_logs("runt1", 1);
    check("runt1_rdy_low", 32'(rdy_low_cnt), 32'd3);

    // 3-beat frame immediately followed by another 3-beat frame
    clear_logs();
    push_stim(16'h0A01, 1, 0); push_stim(16'h0A02, 0, 0); push_stim(16'h0A03, 0, 1);
    push_stim(16'h0B01, 1, 0); push_stim(16'h0B02, 0, 0); push_stim(16'h0B03, 0, 1);
    drive_queue();
    idle(5);
    check("b2b_gap", 32'(acc_q[3] - acc_q[2]), 32'd2);
    exp_strobe_q = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0B01, 16'h0B02, 16'h0B03};
    exp_scyc_q   = '{acc_q[0], acc_q[1], acc_q[2], acc_q[3], acc_q[4], acc_q[5]};
    exp_beat(16'h0A01, 1, 0, 0); exp_beat(16'h0A02, 0, 0, 0); exp_beat(16'h0A03, 0, 1, 0);
    exp_beat(16'h0B01, 1, 0, 0); exp_beat(16'h0B02, 0, 0, 0); exp_beat(16'h0B03, 0, 1, 0);
    compare_logs("b2b", 0);
    check("b2b_rdy_low", 32'(rdy_low_cnt), 32'd2);

    // sop at beat 5: abort beat, drop interrupting frame, recover on next frame
    clear_logs();
    push_stim(16'h1001, 1, 0); push_stim(16'h1002, 0, 0); push_stim(16'h1003, 0, 0);
    push_stim(16'h1004, 0, 0); push_stim(16'h2001, 1, 0); push_stim(16'h2002, 0, 0);
    push_stim(16'h2003, 0, 1);
    push_stim(16'h3001, 1, 0); push_stim(16'h3002, 0, 0); push_stim(16'h3003, 0, 1);
    drive_queue();
    idle(5);
    exp_strobe_q = '{16'h1001, 16'h1002, 16'h1003, 16'h3001, 16'h3002, 16'h3003};
    exp_scyc_q   = '{acc_q[0], acc_q[1], acc_q[2], acc_q[7], acc_q[8], acc_q[9]};
    exp_beat(16'h1001, 1, 0, 0); exp_beat(16'h1002, 0, 0, 0); exp_beat(16'h1003, 0, 0, 0);
    exp_beat(16'h1004, 0, 0, 0); exp_beat(16'h0000, 0, 1, 1);
    exp_beat(16'h3001, 1, 0, 0); exp_beat(16'h3002, 0, 0, 0); exp_beat(16'h3003, 0, 1, 0);
    compare_logs("midsop", 1);

    // out_ready low for 4 cycles mid-body
    clear_logs();
    push_stim(16'h4001, 1, 0); push_stim(16'h4002, 0, 0); push_stim(16'h4003, 0, 0);
    push_stim(16'h4004, 0, 0);
    drive_queue();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_data%0d", i), 32'(out_data), 32'h4004);
      check($sformatf("bp_hold_flags%0d", i), 32'({out_sop, out_eop, out_err}), 32'd0);
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_stim(16'h4005, 0, 0); push_stim(16'h4006, 0, 0); push_stim(16'h4007, 0, 1);
    drive_queue();
    idle(5);
    exp_strobe_q = '{16'h4001, 16'h4002, 16'h4003};
    exp_beat(16'h4001, 1, 0, 0); exp_beat(16'h4002, 0, 0, 0); exp_beat(16'h4003, 0, 0, 0);
    exp_beat(16'h4004, 0, 0, 0); exp_beat(16'h4005, 0, 0, 0); exp_beat(16'h4006, 0, 0, 0);
    exp_beat(16'h4007, 0, 1, 0);
    compare_logs("bp", 0);

    // reset while padding a runt, then a clean frame
    clear_logs();
    push_stim(16'h5555, 1, 1);
    drive_queue();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("padrst_out_valid", 32'(out_valid), 32'd0);
    check("padrst_out_data", 32'(out_data), 32'd0);
    check("padrst_strobe", 32'(dst_mac_valid), 32'd0);
    check("padrst_mac_data", 32'(mac_data), 32'd0);
    check("padrst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
    push_stim(16'h6001, 1, 0); push_stim(16'h6002, 0, 0); push_stim(16'h6003, 0, 0);
    push_stim(16'h6004, 0, 1);
    drive_queue();
    idle(5);
    exp_strobe_q = '{16'h6001, 16'h6002, 16'h6003};
    exp_scyc_q   = '{acc_q[0], acc_q[0] + 1, acc_q[0] + 2};
    exp_beat(16'h6001, 1, 0, 0); exp_beat(16'h6002, 0, 0, 0); exp_beat(16'h6003, 0, 0, 0);
    exp_beat(16'h6004, 0, 1, 0);
    compare_logs("postrst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
